// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

    localparam int unsigned INST_ADDR_W      = 32;
    localparam int unsigned INST_DATA_W      = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Fetch sequencer states; ERROR is terminal until reset.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH_REQ = 3'd1,
        WAIT_RESP = 3'd2,
        HOLD      = 3'd3,
        WAIT_NPC  = 3'd4,
        ERROR     = 3'd5
    } ifu_state_e;

    // Instruction addresses must be word aligned.
    function automatic logic word_aligned(input logic [INST_ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from
// instruction memory, hands it to decode, then waits for execute's next PC.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [INST_ADDR_W-1:0] imem_req_addr,
    input  logic                   imem_rsp_valid,
    output logic                   imem_rsp_ready,
    input  logic [INST_DATA_W-1:0] imem_rsp_data,
    input  logic                   imem_rsp_err,
    output logic                   inst_valid_if,
    input  logic                   inst_ready_id,
    output logic [INST_DATA_W-1:0] inst_if,
    output logic [INST_ADDR_W-1:0] pc_if,
    input  logic                   npc_valid_ex,
    input  logic [INST_ADDR_W-1:0] dnpc,
    output logic                   fetch_err,
    output logic [CNT_W-1:0]       fetch_cnt
);

    ifu_state_e             state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [INST_DATA_W-1:0] inst_q, inst_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   req_valid_q;
    logic                   rsp_ready_q;
    logic                   inst_valid_q;

    // Next-state and datapath update for the fetch sequencer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT_RESP;
                end else begin
                    state_d = FETCH_REQ;
                end
            end
            WAIT_RESP: begin
                if (imem_rsp_valid && imem_rsp_err) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else if (imem_rsp_valid) begin
                    inst_d  = imem_rsp_data;
                    state_d = HOLD;
                end else begin
                    state_d = WAIT_RESP;
                end
            end
            HOLD: begin
                if (inst_ready_id) begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = WAIT_NPC;
                end else begin
                    state_d = HOLD;
                end
            end
            WAIT_NPC: begin
                if (npc_valid_ex && word_aligned(dnpc)) begin
                    pc_d    = dnpc;
                    state_d = FETCH_REQ;
                end else if (npc_valid_ex) begin
                    // Misaligned target: keep the old PC for post-mortem.
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    state_d = WAIT_NPC;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                // Corrupted state encoding is treated as a fault.
                err_d   = 1'b1;
                state_d = ERROR;
            end
        endcase
    end

    // State, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= {INST_DATA_W{1'b0}};
            err_q        <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            req_valid_q  <= 1'b0;
            rsp_ready_q  <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            req_valid_q  <= (state_d == FETCH_REQ);
            rsp_ready_q  <= (state_d == WAIT_RESP);
            inst_valid_q <= (state_d == HOLD);
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign imem_rsp_ready = rsp_ready_q;
    assign inst_valid_if  = inst_valid_q;
    assign inst_if        = inst_q;
    assign pc_if          = pc_q;
    assign fetch_err      = err_q;
    assign fetch_cnt      = cnt_q;

endmodule
